// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: opcodes, flag bit positions, sequencer states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  // Bit positions inside the {Z,N,C,V} flag nibble.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: computes result, {Z,N,C,V} flags and an illegal-opcode indication.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when to register the outputs.
// Ports: op/a/b in; result, flags {Z,N,C,V}, illegal out.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0]  shamt;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] shl_ext;
  logic [WIDTH:0] shr_ext;
  logic           c;
  logic           v;

  assign shamt = b[SW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  // One spare bit on the exit side of each shift catches the last bit shifted out;
  // it is naturally 0 for a zero shift amount.
  assign shl_ext = {1'b0, a} << shamt;
  assign shr_ext = {a, 1'b0} >> shamt;

  always_comb begin
    result  = '0;
    c       = 1'b0;
    v       = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        result = diff[WIDTH-1:0];
        c      = ~diff[WIDTH];  // no borrow means A >= B unsigned
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = shl_ext[WIDTH-1:0];
        c      = shl_ext[WIDTH];
      end
      OP_SHR: begin
        result = shr_ext[WIDTH:1];
        c      = shr_ext[0];
      end
      OP_MOV: result = b;
      default: illegal = 1'b1;
    endcase

    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/alu_datapath_p.sv
// Register bank + operand muxes + ALU under a 3-state IDLE/EXEC/WB sequencer.
// Latency: result pulse (res_valid) in the cycle after the 2nd edge following accept; 1 command per 3 cycles.
// Backpressure: cmd_ready is high only in IDLE (and never during reset); command fields sampled only on accept.
// Ports: clk/reset; cmd_* command in with valid/ready; res_* completion out; dbg_addr/dbg_data registered debug read.
module alu_datapath_p
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_ra,
  input  logic [AW-1:0]    cmd_rb,
  input  logic             cmd_use_imm,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [3:0]       res_flags,
  output logic             res_err,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] regs [NREGS];

  logic [3:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] ex_res_q;
  logic [3:0]       ex_flags_q;
  logic             ex_ill_q;

  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic             alu_ill;
  logic             accept;

  // Gating with reset makes a same-cycle reset win over an incoming command.
  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op      (op_q),
    .a       (opa_q),
    .b       (opb_q),
    .result  (alu_res),
    .flags   (alu_flags),
    .illegal (alu_ill)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      ex_res_q   <= '0;
      ex_flags_q <= '0;
      ex_ill_q   <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_flags  <= '0;
      res_err    <= 1'b0;
      dbg_data   <= '0;
    end else begin
      res_valid <= 1'b0;
      dbg_data  <= regs[dbg_addr];
      case (state)
        ST_IDLE: begin
          if (accept) begin
            opa_q <= regs[cmd_ra];
            opb_q <= cmd_use_imm ? cmd_imm : regs[cmd_rb];
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
          end
        end
        ST_EXEC: begin
          ex_res_q   <= alu_res;
          ex_flags_q <= alu_flags;
          ex_ill_q   <= alu_ill;
        end
        ST_WB: begin
          if (!ex_ill_q && (op_q != OP_CMP)) regs[rd_q] <= ex_res_q;
          // Illegal opcodes leave the previous flags visible.
          if (!ex_ill_q) res_flags <= ex_flags_q;
          res_data  <= ex_res_q;
          res_err   <= ex_ill_q;
          res_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_datapath_p.sv
module tb_alu_datapath_p;

  localparam int W  = 16;
  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_rd, cmd_ra, cmd_rb;
  logic          cmd_use_imm;
  logic [W-1:0]  cmd_imm;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic [3:0]    res_flags;
  logic          res_err;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: architectural registers and last flags.
  logic [W-1:0] mregs [N];
  logic [3:0]   mflags;

  alu_datapath_p #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
    .res_valid(res_valid), .res_data(res_data), .res_flags(res_flags), .res_err(res_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the architectural state.
  function automatic void model_cmd(input logic [3:0] op, input logic [AW-1:0] rd, ra, rb,
                                    input logic ui, input logic [W-1:0] imm,
                                    output logic [W-1:0] r, output logic [3:0] fl, output logic err);
    int ua, ub, sa, sb, s, t;
    logic c, v;
    ua = int'(mregs[ra]);
    ub = ui ? int'(imm) : int'(mregs[rb]);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    s  = ub % 16;
    c = 1'b0; v = 1'b0; err = 1'b0; r = '0; t = 0;
    case (op)
      4'd0: begin t = ua + ub; r = 16'(t); c = (t > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
      4'd1, 4'd9: begin t = ua - ub; r = 16'(t); c = (ua >= ub); v = (sa - sb > 32767) || (sa - sb < -32768); end
      4'd2: r = 16'(ua & ub);
      4'd3: r = 16'(ua | ub);
      4'd4: r = 16'(ua ^ ub);
      4'd5: r = 16'(65535 - ua);
      4'd6: begin r = 16'(ua << s); c = (s != 0) && (((ua >> (16 - s)) % 2) == 1); end
      4'd7: begin r = 16'(ua >> s); c = (s != 0) && (((ua >> (s - 1)) % 2) == 1); end
      4'd8: r = 16'(ub);
      default: err = 1'b1;
    endcase
    if (err) begin
      fl = mflags;
    end else begin
      fl = {(r == 16'd0), r[15], c, v};
      mflags = fl;
      if (op != 4'd9) mregs[rd] = r;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mregs[i] = '0;
    mflags = '0;
  endtask

  task automatic rand_cmd();
    int k;
    k = $urandom_range(0, 3);
    cmd_op      = (k == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    cmd_rd      = 4'($urandom);
    cmd_ra      = 4'($urandom);
    cmd_rb      = 4'($urandom);
    cmd_use_imm = 1'($urandom);
    k = $urandom_range(0, 5);
    cmd_imm     = (k == 0) ? 16'hFFFF : (k == 1) ? 16'h8000 : (k == 2) ? 16'h0000 : 16'($urandom);
  endtask

  // Issues one command, scrambles the inputs after accept, returns latency and result.
  task automatic run_cmd(input logic [3:0] op, input logic [AW-1:0] rd, ra, rb, input logic ui,
                         input logic [W-1:0] imm, output int lat, output logic [W-1:0] d,
                         output logic [3:0] f, output logic e);
    int w;
    w = 0;
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_use_imm = ui; cmd_imm = imm;
    cmd_valid = 1'b1;
    while (!cmd_ready && w < 10) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rand_cmd();
    lat = 1;
    while (!res_valid && lat < 8) begin @(negedge clk); lat++; end
    d = res_data; f = res_flags; e = res_err;
  endtask

  task automatic dbg_read(input logic [AW-1:0] a, output logic [W-1:0] d);
    @(negedge clk);
    dbg_addr = a;
    @(posedge clk);
    #1 d = dbg_data;
  endtask

  task automatic test_reset();
    logic [W-1:0] d;
    reset = 1'b1; cmd_valid = 1'b0; dbg_addr = '0; rand_cmd();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_in_reset: got %b required 0", cmd_ready); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b required 1", cmd_ready); end
    n_checks++;
    if ({res_valid, res_err, res_flags, res_data} !== 22'd0) begin
      n_fail++; $display("FAIL reset_outputs: valid=%b err=%b flags=%b data=%h required all 0", res_valid, res_err, res_flags, res_data);
    end
    for (int i = 0; i < N; i++) begin
      dbg_read(4'(i), d);
      n_checks++;
      if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_reg%0d: got %h required 0000", i, d); end
    end
    model_reset();
  endtask

  task automatic test_mov_add();
    int lat; logic [W-1:0] d, ed; logic [3:0] f, ef; logic e, ee;
    model_cmd(4'd8, 4'd1, 4'd0, 4'd0, 1'b1, 16'h7FFF, ed, ef, ee);
    run_cmd(4'd8, 4'd1, 4'd0, 4'd0, 1'b1, 16'h7FFF, lat, d, f, e);
    n_checks++;
    if (lat !== 3 || d !== 16'h7FFF || f !== 4'b0000 || e !== 1'b0) begin
      n_fail++; $display("FAIL mov_imm: lat=%0d data=%h flags=%b err=%b required 3 7fff 0000 0", lat, d, f, e);
    end
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL valid_one_cycle: got %b required 0", res_valid); end
    model_cmd(4'd0, 4'd2, 4'd1, 4'd0, 1'b1, 16'h0001, ed, ef, ee);
    run_cmd(4'd0, 4'd2, 4'd1, 4'd0, 1'b1, 16'h0001, lat, d, f, e);
    n_checks++;
    if (lat !== 3 || d !== 16'h8000 || f !== 4'b0101 || e !== 1'b0) begin
      n_fail++; $display("FAIL add_overflow: lat=%0d data=%h flags=%b err=%b required 3 8000 0101 0", lat, d, f, e);
    end
  endtask

  task automatic test_sub_cmp();
    int lat; logic [W-1:0] d, ed; logic [3:0] f, ef; logic e, ee;
    model_cmd(4'd1, 4'd3, 4'd2, 4'd2, 1'b0, 16'h1234, ed, ef, ee);
    run_cmd(4'd1, 4'd3, 4'd2, 4'd2, 1'b0, 16'h1234, lat, d, f, e);
    n_checks++;
    if (lat !== 3 || d !== 16'h0000 || f !== 4'b1010 || e !== 1'b0) begin
      n_fail++; $display("FAIL sub_zero: lat=%0d data=%h flags=%b err=%b required 3 0000 1010 0", lat, d, f, e);
    end
    model_cmd(4'd9, 4'd5, 4'd1, 4'd0, 1'b1, 16'hFFFF, ed, ef, ee);
    run_cmd(4'd9, 4'd5, 4'd1, 4'd0, 1'b1, 16'hFFFF, lat, d, f, e);
    n_checks++;
    if (lat !== 3 || d !== 16'h8000 || f !== 4'b0101 || e !== 1'b0) begin
      n_fail++; $display("FAIL cmp_borrow: lat=%0d data=%h flags=%b err=%b required 3 8000 0101 0", lat, d, f, e);
    end
    dbg_read(4'd5, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL cmp_no_write: r5=%h required 0000", d); end
    dbg_read(4'd1, d);
    n_checks++;
    if (d !== 16'h7FFF) begin n_fail++; $display("FAIL cmp_src_kept: r1=%h required 7fff", d); end
  endtask

  task automatic test_shift_illegal();
    int lat; logic [W-1:0] d, ed; logic [3:0] f, ef; logic e, ee;
    model_cmd(4'd8, 4'd6, 4'd0, 4'd0, 1'b1, 16'h8001, ed, ef, ee);
    run_cmd(4'd8, 4'd6, 4'd0, 4'd0, 1'b1, 16'h8001, lat, d, f, e);
    model_cmd(4'd6, 4'd7, 4'd6, 4'd0, 1'b1, 16'h0001, ed, ef, ee);
    run_cmd(4'd6, 4'd7, 4'd6, 4'd0, 1'b1, 16'h0001, lat, d, f, e);
    n_checks++;
    if (lat !== 3 || d !== 16'h0002 || f !== 4'b0010 || e !== 1'b0) begin
      n_fail++; $display("FAIL shl_carry: lat=%0d data=%h flags=%b err=%b required 3 0002 0010 0", lat, d, f, e);
    end
    model_cmd(4'd12, 4'd1, 4'd2, 4'd3, 1'b0, 16'h5555, ed, ef, ee);
    run_cmd(4'd12, 4'd1, 4'd2, 4'd3, 1'b0, 16'h5555, lat, d, f, e);
    n_checks++;
    if (lat !== 3 || d !== 16'h0000 || f !== 4'b0010 || e !== 1'b1) begin
      n_fail++; $display("FAIL illegal_op: lat=%0d data=%h flags=%b err=%b required 3 0000 0010 1", lat, d, f, e);
    end
    dbg_read(4'd1, d);
    n_checks++;
    if (d !== 16'h7FFF) begin n_fail++; $display("FAIL illegal_no_write: r1=%h required 7fff", d); end
    model_cmd(4'd7, 4'd8, 4'd7, 4'd0, 1'b1, 16'h0000, ed, ef, ee);
    run_cmd(4'd7, 4'd8, 4'd7, 4'd0, 1'b1, 16'h0000, lat, d, f, e);
    n_checks++;
    if (lat !== 3 || d !== 16'h0002 || f !== 4'b0000 || e !== 1'b0) begin
      n_fail++; $display("FAIL shr_zero: lat=%0d data=%h flags=%b err=%b required 3 0002 0000 0", lat, d, f, e);
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] d;
    int pulses;
    int w;
    w = 0;
    @(negedge clk);
    cmd_op = 4'd0; cmd_rd = 4'd4; cmd_ra = 4'd1; cmd_rb = 4'd0; cmd_use_imm = 1'b1; cmd_imm = 16'h0005;
    cmd_valid = 1'b1;
    while (!cmd_ready && w < 10) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);             // sequencer is in EXEC here
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (5) begin @(negedge clk); if (res_valid) pulses++; end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL abort_no_valid: pulses=%0d required 0", pulses); end
    model_reset();
    dbg_read(4'd4, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL abort_no_write: r4=%h required 0000", d); end
    dbg_read(4'd1, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL abort_reset_regs: r1=%h required 0000", d); end
    n_checks++;
    if (res_flags !== 4'b0000) begin n_fail++; $display("FAIL abort_flags: got %b required 0000", res_flags); end
    // Command presented during reset must not be taken.
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b1;
    cmd_op = 4'd8; cmd_rd = 4'd9; cmd_use_imm = 1'b1; cmd_imm = 16'h1234;
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0;
    pulses = 0;
    repeat (5) begin @(negedge clk); if (res_valid) pulses++; end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL reset_wins_valid: pulses=%0d required 0", pulses); end
    dbg_read(4'd9, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_wins_write: r9=%h required 0000", d); end
  endtask

  task automatic test_back_to_back();
    localparam int NCMD = 150;
    int cyc, last, acc;
    logic [W-1:0] ed, d;
    logic [3:0]   ef;
    logic         ee;
    logic [20:0]  exp_r;
    logic [20:0]  expq [$];
    cyc = 0; last = -1; acc = 0;
    @(negedge clk);
    rand_cmd();
    cmd_valid = 1'b1;
    while ((acc < NCMD || expq.size() > 0) && cyc < 2000) begin
      if (res_valid) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_pulse: cycle %0d", cyc);
        end else begin
          exp_r = expq.pop_front();
          if ({res_data, res_flags, res_err} !== exp_r) begin
            n_fail++;
            $display("FAIL b2b_result: data=%h flags=%b err=%b required data=%h flags=%b err=%b",
                     res_data, res_flags, res_err, exp_r[20:5], exp_r[4:1], exp_r[0]);
          end
        end
      end
      if (cmd_ready && acc < NCMD) begin
        if (last >= 0) begin
          n_checks++;
          if (cyc - last != 3) begin n_fail++; $display("FAIL b2b_interval: got %0d required 3", cyc - last); end
        end
        last = cyc;
        acc++;
        model_cmd(cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_use_imm, cmd_imm, ed, ef, ee);
        expq.push_back({ed, ef, ee});
      end else if (acc >= NCMD) begin
        cmd_valid = 1'b0;
      end else begin
        rand_cmd();   // must be ignored while not ready
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (cyc >= 2000) begin n_fail++; $display("FAIL b2b_timeout: accepted %0d pending %0d", acc, expq.size()); end
    for (int i = 0; i < N; i++) begin
      dbg_read(4'(i), d);
      n_checks++;
      if (d !== mregs[i]) begin n_fail++; $display("FAIL b2b_reg%0d: got %h required %h", i, d, mregs[i]); end
    end
    n_checks++;
    if (res_flags !== mflags) begin n_fail++; $display("FAIL b2b_flags: got %b required %b", res_flags, mflags); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mov_add();
    test_sub_cmp();
    test_shift_illegal();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
